tr_sequencer: RTL and testbench

//  Sequences the TX/RX power and T/R switching resource (relays, op-amp supply, PA bias, PA supply) from one tx request.

---
 rtl/tr_seq_pkg.sv | 29 ++
 rtl/tr_seq_timer.sv | 36 +++
 rtl/tr_sequencer.sv | 133 +++++++++++++
 tb/tb_tr_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tr_seq_pkg.sv
// Shared types and default dwell constants for the TX/RX power and T/R switch sequencer.
package tr_seq_pkg;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        TX_SW      = 3'd1,
        TX_BIAS    = 3'd2,
        TX_ON      = 3'd3,
        TX_DRAIN   = 3'd4,
        RX_PWR_OFF = 3'd5,
        RX_SETTLE  = 3'd6,
        FAULT      = 3'd7
    } tr_state_t;

    // Field order matches the cfg_data word, t_relay in the top byte.
    typedef struct packed {
        logic [7:0] t_relay;
        logic [7:0] t_bias;
        logic [7:0] t_drain;
        logic [7:0] t_release;
    } tr_cfg_t;

    localparam int         TICK_DIV_DEF  = 25;
    localparam logic [7:0] T_RELAY_DEF   = 8'd10;
    localparam logic [7:0] T_BIAS_DEF    = 8'd5;
    localparam logic [7:0] T_DRAIN_DEF   = 8'd2;
    localparam logic [7:0] T_RELEASE_DEF = 8'd3;

endpackage

// File: rtl/tr_seq_timer.sv
// Dwell timer: a TICK_DIV prescaler feeding an 8-bit tick counter; done while the count is zero.
module tr_seq_timer #(
    parameter int TICK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_n,
    output logic       o_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [7:0]    r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_pre <= PRE_RELOAD;
            r_cnt <= i_n;
        end else if (r_pre == '0) begin
            r_pre <= PRE_RELOAD;
            if (r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
        end else begin
            r_pre <= r_pre - 1'b1;
        end
    end

    assign o_done = (r_cnt == 8'd0);

endmodule

// File: rtl/tr_sequencer.sv
// Orders T/R relay, op-amp supply, PA bias and PA supply around a TX request, with
// programmable dwell per step, a tx_ready gate and abort to FAULT on inhibit.
module tr_sequencer
    import tr_seq_pkg::*;
#(
    parameter int         TICK_DIV  = TICK_DIV_DEF,
    parameter logic [7:0] T_RELAY   = T_RELAY_DEF,
    parameter logic [7:0] T_BIAS    = T_BIAS_DEF,
    parameter logic [7:0] T_DRAIN   = T_DRAIN_DEF,
    parameter logic [7:0] T_RELEASE = T_RELEASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_req,
    input  logic        inhibit,
    input  logic        vna,
    input  logic        pa_enable,
    input  logic        tr_disable,
    input  logic        cfg_wr,
    input  logic [31:0] cfg_data,
    output logic        pa_exttr,
    output logic        pa_inttr,
    output logic        pwr_envop,
    output logic        pwr_envbias,
    output logic        pwr_envpa,
    output logic        rffe_rfsw_sel,
    output logic        tx_ready,
    output logic        busy,
    output logic        inhibited
);

    localparam tr_cfg_t CFG_RST = '{T_RELAY, T_BIAS, T_DRAIN, T_RELEASE};

    tr_state_t r_state, w_next;
    tr_cfg_t   r_cfg;
    logic      r_mode_pa, r_mode_int;
    logic      w_capture, w_mp, w_mi, w_load, w_done;
    logic [7:0] w_dwell;
    logic [5:0] w_out;   // {exttr, inttr, envop, envbias, envpa, tx_ready}

    tr_seq_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_n    (w_dwell),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_next;
    end

    // Inhibit outranks everything outside idle; tx_req drop outranks dwell expiry.
    always_comb begin
        w_next = r_state;
        if (inhibit && r_state != RX_IDLE) begin
            w_next = FAULT;
        end else begin
            case (r_state)
                RX_IDLE:    if (tx_req && !inhibit) w_next = TX_SW;
                TX_SW:      if (!tx_req) w_next = RX_SETTLE;  else if (w_done) w_next = TX_BIAS;
                TX_BIAS:    if (!tx_req) w_next = RX_PWR_OFF; else if (w_done) w_next = TX_ON;
                TX_ON:      if (!tx_req) w_next = TX_DRAIN;
                TX_DRAIN:   if (tx_req)  w_next = TX_ON;      else if (w_done) w_next = RX_PWR_OFF;
                RX_PWR_OFF: if (w_done)  w_next = RX_SETTLE;
                RX_SETTLE:  if (w_done)  w_next = RX_IDLE;
                FAULT:      if (!inhibit) w_next = RX_SETTLE;
                default:    w_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        w_dwell = 8'd0;
        case (w_next)
            TX_SW, RX_SETTLE: w_dwell = r_cfg.t_relay;
            TX_BIAS:          w_dwell = r_cfg.t_bias;
            TX_DRAIN:         w_dwell = r_cfg.t_drain;
            RX_PWR_OFF:       w_dwell = r_cfg.t_release;
            default:          w_dwell = 8'd0;
        endcase
    end

    assign w_load    = (w_next != r_state);
    assign w_capture = (r_state == RX_IDLE) && (w_next == TX_SW);
    assign w_mp      = w_capture ? (~vna & pa_enable) : r_mode_pa;
    assign w_mi      = w_capture ? ((~vna & pa_enable) | ~tr_disable) : r_mode_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg      <= CFG_RST;
            r_mode_pa  <= 1'b0;
            r_mode_int <= 1'b0;
        end else begin
            if (cfg_wr)
                r_cfg <= tr_cfg_t'(cfg_data);
            if (w_capture) begin
                r_mode_pa  <= w_mp;
                r_mode_int <= w_mi;
            end
        end
    end

    // Decode from next-state so the pins move on the same edge as the state.
    always_comb begin
        w_out = 6'b000000;
        case (w_next)
            TX_SW:      w_out = {1'b1, w_mi, 1'b0, 1'b0, 1'b0, 1'b0};
            TX_BIAS:    w_out = {1'b1, w_mi, 1'b1, w_mp, 1'b0, 1'b0};
            TX_ON:      w_out = {1'b1, w_mi, 1'b1, w_mp, w_mp, 1'b1};
            TX_DRAIN:   w_out = {1'b1, w_mi, 1'b1, w_mp, w_mp, 1'b0};
            RX_PWR_OFF: w_out = {1'b1, w_mi, 1'b0, 1'b0, 1'b0, 1'b0};
            default:    w_out = 6'b000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {pa_exttr, pa_inttr, pwr_envop, pwr_envbias, pwr_envpa, tx_ready} <= 6'b000000;
            rffe_rfsw_sel <= 1'b0;
            busy          <= 1'b0;
            inhibited     <= 1'b0;
        end else begin
            {pa_exttr, pa_inttr, pwr_envop, pwr_envbias, pwr_envpa, tx_ready} <= w_out;
            if (r_state == RX_IDLE)
                rffe_rfsw_sel <= ~vna & pa_enable;
            busy      <= (w_next != RX_IDLE);
            inhibited <= (w_next == FAULT);
        end
    end

endmodule

// File: tb/tb_tr_sequencer.sv
// Scoreboard bench: stimulus queues expected output vectors with their cycle; a negedge
// monitor pops one entry each time the DUT output vector changes and compares.
module tb_tr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_req = 1'b0, inhibit = 1'b0, vna = 1'b0, pa_enable = 1'b1, tr_disable = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [31:0] cfg_data = 32'h0;
    logic pa_exttr, pa_inttr, pwr_envop, pwr_envbias, pwr_envpa, rffe_rfsw_sel, tx_ready, busy, inhibited;

    tr_sequencer dut (
        .clk(clk), .rst(rst), .tx_req(tx_req), .inhibit(inhibit), .vna(vna),
        .pa_enable(pa_enable), .tr_disable(tr_disable), .cfg_wr(cfg_wr), .cfg_data(cfg_data),
        .pa_exttr(pa_exttr), .pa_inttr(pa_inttr), .pwr_envop(pwr_envop), .pwr_envbias(pwr_envbias),
        .pwr_envpa(pwr_envpa), .rffe_rfsw_sel(rffe_rfsw_sel), .tx_ready(tx_ready), .busy(busy),
        .inhibited(inhibited)
    );

    always #5 clk = ~clk;

    // {exttr,inttr,envop,envbias,envpa,rfsw,tx_ready,busy,inhibited}
    localparam logic [8:0] V_IDLE  = 9'b000001000;
    localparam logic [8:0] V_SW    = 9'b110001010;
    localparam logic [8:0] V_BIAS  = 9'b111101010;
    localparam logic [8:0] V_ON    = 9'b111111110;
    localparam logic [8:0] V_DRAIN = 9'b111111010;
    localparam logic [8:0] V_OFF   = 9'b110001010;
    localparam logic [8:0] V_SETL  = 9'b000001010;
    localparam logic [8:0] V_FAULT = 9'b000001011;
    // vna=1, tr_disable=1: no inttr, no bias/PA supply, rfsw low
    localparam logic [8:0] N_IDLE  = 9'b000000000;
    localparam logic [8:0] N_SW    = 9'b100000010;
    localparam logic [8:0] N_BIAS  = 9'b101000010;
    localparam logic [8:0] N_ON    = 9'b101000110;
    localparam logic [8:0] N_DRAIN = 9'b101000010;
    localparam logic [8:0] N_OFF   = 9'b100000010;
    localparam logic [8:0] N_SETL  = 9'b000000010;

    typedef struct {
        int         cyc;
        logic [8:0] v;
        string      name;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    logic mon_en = 1'b0;
    logic [8:0] prev = '0;
    logic [8:0] outv;

    assign outv = {pa_exttr, pa_inttr, pwr_envop, pwr_envbias, pwr_envpa,
                   rffe_rfsw_sel, tx_ready, busy, inhibited};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (outv !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%b", cyc, outv);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || e.v !== outv) begin
                        failures++;
                        $display("FAIL %s got cyc=%0d out=%b, want cyc=%0d out=%b",
                                 e.name, cyc, outv, e.cyc, e.v);
                    end
                end
            end
            prev = outv;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [8:0] v, input string nm);
        ev_t e;
        e.cyc = at; e.v = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic drained(input string nm);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing got pending=%0d want 0 next=%s@%0d", nm, q.size(), q[0].name, q[0].cyc);
            q.delete();
        end
    endtask

    task automatic ramp_up(input logic [8:0] sw, input logic [8:0] bias, input logic [8:0] on, input string nm);
        int t;
        t = cyc;
        tx_req = 1'b1;
        push(t + 1,   sw,   {nm, "_sw"});
        push(t + 252, bias, {nm, "_bias"});
        push(t + 378, on,   {nm, "_on"});
        tick(400);
        drained({nm, "_up"});
    endtask

    task automatic ramp_down(input logic [8:0] dr, input logic [8:0] off, input logic [8:0] st,
                             input logic [8:0] idl, input string nm);
        int t;
        t = cyc;
        tx_req = 1'b0;
        push(t + 1,   dr,  {nm, "_drain"});
        push(t + 52,  off, {nm, "_pwroff"});
        push(t + 128, st,  {nm, "_settle"});
        push(t + 379, idl, {nm, "_idle"});
        tick(400);
        drained({nm, "_down"});
    endtask

    initial begin
        int t;
        tick(3);
        checks++;
        if (outv !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", outv, 9'b0);
        end
        prev   = outv;
        mon_en = 1'b1;
        t = cyc;
        rst = 1'b0;
        push(t + 1, V_IDLE, "post_reset_rfsw");
        tick(5);
        drained("post_reset");

        ramp_up(V_SW, V_BIAS, V_ON, "pa");
        ramp_down(V_DRAIN, V_OFF, V_SETL, V_IDLE, "pa");

        // VNA with internal relay disabled
        t = cyc; vna = 1'b1; tr_disable = 1'b1;
        push(t + 1, N_IDLE, "vna_rfsw");
        tick(5);
        ramp_up(N_SW, N_BIAS, N_ON, "vna");
        ramp_down(N_DRAIN, N_OFF, N_SETL, N_IDLE, "vna");
        t = cyc; vna = 1'b0; tr_disable = 1'b0;
        push(t + 1, V_IDLE, "vna_exit_rfsw");
        tick(5);
        drained("vna_exit");

        // inhibit while idle blocks the request and raises nothing
        tx_req = 1'b1; inhibit = 1'b1;
        tick(10);
        tx_req = 1'b0;
        tick(1);
        inhibit = 1'b0;
        tick(5);
        drained("idle_inhibit");

        // inhibit in TX_ON with tx_req still high
        ramp_up(V_SW, V_BIAS, V_ON, "inh");
        t = cyc; inhibit = 1'b1;
        push(t + 1, V_FAULT, "inh_fault");
        tick(5);
        tx_req = 1'b0;
        tick(5);
        t = cyc; inhibit = 1'b0;
        push(t + 1,   V_SETL, "inh_settle");
        push(t + 252, V_IDLE, "inh_idle");
        tick(270);
        drained("inh");

        // drain cancel: reassert during TX_DRAIN
        ramp_up(V_SW, V_BIAS, V_ON, "cancel");
        t = cyc; tx_req = 1'b0;
        push(t + 1, V_DRAIN, "cancel_drain");
        tick(10);
        t = cyc; tx_req = 1'b1;
        push(t + 1, V_ON, "cancel_reon");
        tick(100);
        drained("cancel");
        ramp_down(V_DRAIN, V_OFF, V_SETL, V_IDLE, "cancel");

        // zero dwell
        cfg_wr = 1'b1; cfg_data = 32'h0000_0000;
        tick(1);
        cfg_wr = 1'b0;
        t = cyc; tx_req = 1'b1;
        push(t + 1, V_SW,   "z_sw");
        push(t + 2, V_BIAS, "z_bias");
        push(t + 3, V_ON,   "z_on");
        tick(10);
        drained("zero_up");

        // reset mid-sequence, then defaults must be restored
        t = cyc; rst = 1'b1;
        push(t + 1, 9'b0, "midrst_zero");
        tick(3);
        t = cyc; rst = 1'b0; tx_req = 1'b0;
        push(t + 1, V_IDLE, "midrst_idle");
        tick(5);
        drained("midrst");
        ramp_up(V_SW, V_BIAS, V_ON, "dflt");
        ramp_down(V_DRAIN, V_OFF, V_SETL, V_IDLE, "dflt");

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
